instr_fetch_unit: RTL

//   Instruction-fetch stage of the MIPS datapath, directly upstream of the opcode decode/control stage.

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read channel, redirect inputs
// and the valid/ready channel toward decode.
//   master : the fetch unit (drives imem_req/imem_addr and instr_valid/instr/instr_pc)
//   slave  : the environment (memory + decode), driving ack/rdata, redirect and ready
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, branch_taken, branch_target, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, branch_taken, branch_target, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads to instruction
// memory, registers each returned instruction and hands it to decode over a
// valid/ready channel. A taken branch redirects the PC and squashes any
// in-flight or held instruction, followed by a one-cycle bubble.
// Ports:
//   clk, reset  : single clock, synchronous active-high reset
//   bus         : instr_fetch_unit_if.master (imem req/ack, redirect, decode handshake)
//   fetch_count : completed fetches (only with FETCH_STATS_EN)
//   flush_count : cycles with branch_taken=1 (only with FETCH_STATS_EN)
// Optional feature macro: FETCH_STATS_EN.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 5,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_fetch_unit_if.master     bus
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]            fetch_count,
  output logic [15:0]            flush_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, REDIR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_p0;
  logic [DATA_W-1:0] instr_p1;
  logic [ADDR_W-1:0] instr_pc_p1;
  logic              vld_p1;
  logic              fetch_done;

  // PC advance wraps modulo 2^ADDR_W with no overflow indication.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = bus.branch_taken ? REDIR : RUN;
      RUN:     state_next = bus.branch_taken ? REDIR : RUN;
      REDIR:   state_next = bus.branch_taken ? REDIR : RUN;
      default: state_next = IDLE;
    endcase
  end

  // Request only when the output slot is free or being drained this cycle,
  // and never in a redirect cycle (the address is about to change).
  assign bus.imem_req  = (state == RUN) && !bus.branch_taken && (!vld_p1 || bus.instr_ready);
  assign bus.imem_addr = pc_p0;
  assign fetch_done    = bus.imem_req && bus.imem_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // p0 -> p1: PC register and fetched-instruction output register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0       <= RESET_PC;
      vld_p1      <= 1'b0;
      instr_p1    <= '0;
      instr_pc_p1 <= '0;
    end else if (bus.branch_taken) begin
      // Redirect wins over ack and accept: the same-cycle fetch is dropped.
      pc_p0  <= bus.branch_target;
      vld_p1 <= 1'b0;
    end else if (fetch_done) begin
      instr_p1    <= bus.imem_rdata;
      instr_pc_p1 <= pc_p0;
      vld_p1      <= 1'b1;
      pc_p0       <= pc_inc(pc_p0);
    end else if (vld_p1 && bus.instr_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.instr_valid = vld_p1;
  assign bus.instr       = instr_p1;
  assign bus.instr_pc    = instr_pc_p1;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (fetch_done && !bus.branch_taken) fetch_count <= fetch_count + 16'd1;
      if (bus.branch_taken)                flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule
